mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port synchronous RAM between three requesters: 0=instruction fetch (PC),
//  1=data access (control unit load/store), 2=program loader (external/debug).
//  Issues at most one RAM access per cycle and returns read data to the winning requester.
//  Sits between the CPU's program counter / control unit and the RAM.
// PARAMETERS
//  ADDR_W  8   RAM address width
//  DATA_W  16  RAM data width
//  RR_EN   1   1 = round-robin arbitration; 0 = fixed priority (2 > 1 > 0)
// PORTS
//  clk          in   1       clock, all state on rising edge
//  reset        in   1       asynchronous, active-low reset
//  req          in   3       per-requester request, bit i = requester i
//  we           in   3       per-requester write enable (1=write, 0=read)
//  addr         in   3*ADDR_W  per-requester address, requester i at [i*ADDR_W +: ADDR_W]
//  wdata        in   3*DATA_W  per-requester write data, same packing as addr
//  lock         in   1       loader lock: while set, loader keeps exclusive ownership once granted
//  gnt          out  3       one-hot grant pulse, 1 cycle per accepted request
//  rvalid       out  3       one-hot read-data-valid pulse
//  rdata        out  DATA_W  read data, valid when any rvalid bit is set
//  mem_en       out  1       RAM access enable
//  mem_we       out  1       RAM write enable
//  mem_adr      out  ADDR_W  RAM address
//  mem_wdata    out  DATA_W  RAM write data
//  mem_rdata    in   DATA_W  RAM read data, valid 1 cycle after mem_en with mem_we=0
//  busy         out  1       high when any req is pending but not granted this cycle (CPU stall hint)
// BEHAVIOUR
//  - Reset (reset=0): gnt, rvalid, mem_en, mem_we = 0; mem_adr, mem_wdata, rdata = 0;
//    rr pointer = 2 (requester 0 wins first); lock_owner = 0. Any in-flight read is discarded.
//  - Request rule: requester holds req/we/addr/wdata stable until it sees gnt[i]=1;
//    it may drop or change them in the cycle gnt[i] is high.
//  - Decision at edge N uses req sampled at cycle N-1. The winner's gnt bit, mem_en, mem_we,
//    mem_adr and mem_wdata are registered and appear together in cycle N.
//  - Masking: the requester granted in cycle N is excluded from the decision made at edge N+1,
//    so no request is granted twice. Max rate is one grant per requester every 2 cycles;
//    different requesters may be granted back-to-back.
//  - Read latency: gnt in cycle N, mem_rdata sampled at edge N+1, rvalid[i] and rdata in cycle N+1.
//    Total latency is 2 cycles from req. A write produces no rvalid.
//  - RR_EN=1: the search starts at rr pointer+1 (mod 3); the pointer is updated to the winner.
//    RR_EN=0: the highest-index pending requester wins.
//  - Lock: if loader (2) is granted while lock=1, lock_owner is set. While lock_owner=1,
//    requesters 0 and 1 are masked (busy=1 if they request). lock_owner clears on the first
//    cycle lock=0. The loader's own 2-cycle grant spacing still applies.
//  - No pending request: mem_en=0, gnt=0; mem_adr and mem_wdata hold their last values.
//  - rdata holds its last value when rvalid=0.
//  - Simultaneous rvalid (previous read) and gnt (new access) in the same cycle is legal and required.
//  - gnt and rvalid are always one-hot or zero.
// TESTING
//  1. Reset, then req=3'b001 addr0=8'h10 we=0, RAM[10]=16'hBEEF: gnt=001 at +1;
//     rvalid=001 rdata=BEEF at +2.
//  2. req=3'b111 held, RR_EN=1: grant order 0,1,2,0,1,2 on consecutive cycles; never two grants
//     to the same requester in adjacent cycles.
//  3. RR_EN=0, req=3'b011 held: grants 1,0,1,0 (masking), never 0 twice in a row.
//  4. Loader write: lock=1, req2 we=1 addr=8'h20 wdata=16'h1234 with req0 pending:
//     mem_we=1 mem_adr=20 mem_wdata=1234, no rvalid. busy=1 and req0 not granted until lock=0;
//     then gnt=001.
//  5. Assert reset=0 in the cycle after a read grant: rvalid stays 0, all outputs 0 immediately.
//     After release, the first grant goes to requester 0.
//  6. Back-to-back reads by 0 then 1 (addr 01, 02): rvalid=001 overlaps gnt=010;
//     rdata values arrive in grant order.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Three-way arbiter sharing one single-port synchronous RAM between instruction fetch (0),
// data access (1) and the program loader (2); returns read data to the requester that issued it.
module mem_port_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16,
   parameter int RR_EN  = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [2:0]            req,
   input  logic [2:0]            we,
   input  logic [3*ADDR_W-1:0]   addr,
   input  logic [3*DATA_W-1:0]   wdata,
   input  logic                  lock,
   output logic [2:0]            gnt,
   output logic [2:0]            rvalid,
   output logic [DATA_W-1:0]     rdata,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_W-1:0]     mem_adr,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic [DATA_W-1:0]     mem_rdata,
   output logic                  busy
);

   logic [2:0]          r_gnt;
   logic [2:0]          r_rd_pend;
   logic [2:0]          r_rvalid;
   logic [DATA_W-1:0]   r_rdata_hold;
   logic                r_mem_en;
   logic                r_mem_we;
   logic [ADDR_W-1:0]   r_mem_adr;
   logic [DATA_W-1:0]   r_mem_wdata;
   logic [1:0]          r_rr_ptr;
   logic                r_lock_owner;

   logic [2:0]          w_elig;
   logic [2:0]          w_win;
   logic [2:0]          w_rot;
   logic [2:0]          w_low;
   logic [1:0]          w_win_idx;
   logic [ADDR_W-1:0]   w_adr;
   logic [DATA_W-1:0]   w_wdata;

   function automatic logic [2:0] lowest_set(input logic [2:0] v);
      return v & (~v + 3'd1);
   endfunction

   // Last cycle's winner sits out one decision; a held lock shuts out fetch and data ports.
   assign w_elig = req & ~r_gnt & (r_lock_owner ? 3'b100 : 3'b111);

   // Winner selection: rotate eligibility so the search starts after the pointer.
   always_comb begin
      w_rot = 3'b000;
      w_low = 3'b000;
      w_win = 3'b000;
      if (RR_EN != 0) begin
         case (r_rr_ptr)
            2'd0: begin
               w_rot = {w_elig[0], w_elig[2], w_elig[1]};
               w_low = lowest_set(w_rot);
               w_win = {w_low[1], w_low[0], w_low[2]};
            end
            2'd1: begin
               w_rot = {w_elig[1], w_elig[0], w_elig[2]};
               w_low = lowest_set(w_rot);
               w_win = {w_low[0], w_low[2], w_low[1]};
            end
            default: begin
               w_rot = w_elig;
               w_low = lowest_set(w_rot);
               w_win = w_low;
            end
         endcase
      end else begin
         if (w_elig[2])      w_win = 3'b100;
         else if (w_elig[1]) w_win = 3'b010;
         else if (w_elig[0]) w_win = 3'b001;
         else                w_win = 3'b000;
      end
   end

   // Route the winner's address and write data toward the RAM port registers.
   always_comb begin
      w_win_idx = 2'd0;
      w_adr     = {ADDR_W{1'b0}};
      w_wdata   = {DATA_W{1'b0}};
      case (w_win)
         3'b001: begin
            w_win_idx = 2'd0;
            w_adr     = addr[0 +: ADDR_W];
            w_wdata   = wdata[0 +: DATA_W];
         end
         3'b010: begin
            w_win_idx = 2'd1;
            w_adr     = addr[ADDR_W +: ADDR_W];
            w_wdata   = wdata[DATA_W +: DATA_W];
         end
         3'b100: begin
            w_win_idx = 2'd2;
            w_adr     = addr[2*ADDR_W +: ADDR_W];
            w_wdata   = wdata[2*DATA_W +: DATA_W];
         end
         default: begin
            w_win_idx = 2'd0;
            w_adr     = {ADDR_W{1'b0}};
            w_wdata   = {DATA_W{1'b0}};
         end
      endcase
   end

   // Grant/RAM-port registers, read-return pipeline, rr pointer and loader lock.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_gnt        <= 3'b000;
         r_rd_pend    <= 3'b000;
         r_rvalid     <= 3'b000;
         r_rdata_hold <= {DATA_W{1'b0}};
         r_mem_en     <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_adr    <= {ADDR_W{1'b0}};
         r_mem_wdata  <= {DATA_W{1'b0}};
         r_rr_ptr     <= 2'd2;
         r_lock_owner <= 1'b0;
      end else begin
         r_gnt     <= w_win;
         r_mem_en  <= |w_win;
         r_mem_we  <= |(w_win & we);
         r_rd_pend <= w_win & ~we;
         r_rvalid  <= r_rd_pend;
         if (|w_win) begin
            r_mem_adr   <= w_adr;
            r_mem_wdata <= w_wdata;
            r_rr_ptr    <= w_win_idx;
         end else begin
            r_mem_adr   <= r_mem_adr;
            r_mem_wdata <= r_mem_wdata;
            r_rr_ptr    <= r_rr_ptr;
         end
         if (|r_rvalid) r_rdata_hold <= mem_rdata;
         else           r_rdata_hold <= r_rdata_hold;
         if (!lock)          r_lock_owner <= 1'b0;
         else if (w_win[2])  r_lock_owner <= 1'b1;
         else                r_lock_owner <= r_lock_owner;
      end
   end

   // The RAM output is live only in the rvalid cycle; afterwards the captured copy is shown.
   assign rdata     = (|r_rvalid) ? mem_rdata : r_rdata_hold;
   assign gnt       = r_gnt;
   assign rvalid    = r_rvalid;
   assign mem_en    = r_mem_en;
   assign mem_we    = r_mem_we;
   assign mem_adr   = r_mem_adr;
   assign mem_wdata = r_mem_wdata;
   assign busy      = |(req & ~r_gnt);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: one round-robin and one fixed-priority arbiter share the stimulus,
// each backed by its own synchronous RAM model with a fixed content pattern.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  req;
   logic [2:0]  we;
   logic [23:0] addr;
   logic [47:0] wdata;
   logic        lock;

   logic [2:0]  rr_gnt, rr_rvalid, fp_gnt, fp_rvalid;
   logic [15:0] rr_rdata, fp_rdata, rr_mem_wdata, fp_mem_wdata;
   logic [15:0] rr_mem_rdata, fp_mem_rdata;
   logic        rr_mem_en, rr_mem_we, fp_mem_en, fp_mem_we, rr_busy, fp_busy;
   logic [7:0]  rr_mem_adr, fp_mem_adr;
   logic [7:0]  rr_last_wr_adr;
   logic [15:0] rr_last_wr_data;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   function automatic logic [15:0] ram_word(input logic [7:0] a);
      case (a)
         8'h01:   return 16'h1111;
         8'h02:   return 16'h2222;
         8'h03:   return 16'h3333;
         8'h10:   return 16'hBEEF;
         default: return {8'h5A, a};
      endcase
   endfunction

   always @(posedge clk) begin
      if (rr_mem_en && !rr_mem_we) rr_mem_rdata <= ram_word(rr_mem_adr);
      if (rr_mem_en && rr_mem_we) begin
         rr_last_wr_adr  <= rr_mem_adr;
         rr_last_wr_data <= rr_mem_wdata;
      end
      if (fp_mem_en && !fp_mem_we) fp_mem_rdata <= ram_word(fp_mem_adr);
   end

   mem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .RR_EN(1)) u_rr (
      .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata), .lock(lock),
      .gnt(rr_gnt), .rvalid(rr_rvalid), .rdata(rr_rdata), .mem_en(rr_mem_en), .mem_we(rr_mem_we),
      .mem_adr(rr_mem_adr), .mem_wdata(rr_mem_wdata), .mem_rdata(rr_mem_rdata), .busy(rr_busy));

   mem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .RR_EN(0)) u_fp (
      .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata), .lock(lock),
      .gnt(fp_gnt), .rvalid(fp_rvalid), .rdata(fp_rdata), .mem_en(fp_mem_en), .mem_we(fp_mem_we),
      .mem_adr(fp_mem_adr), .mem_wdata(fp_mem_wdata), .mem_rdata(fp_mem_rdata), .busy(fp_busy));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      step();
      reset = 1'b0;
      req   = 3'b000;
      we    = 3'b000;
      lock  = 1'b0;
      step();
      step();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      step();
      reset = 1'b0;
      req   = 3'b000;
      we    = 3'b000;
      lock  = 1'b0;
      addr  = 24'h000000;
      wdata = 48'h0;
      step();
      n_checks++;
      if ({rr_gnt, rr_rvalid, rr_mem_en, rr_mem_we} !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b expected 00000000", {rr_gnt, rr_rvalid, rr_mem_en, rr_mem_we});
      end
      n_checks++;
      if ({rr_mem_adr, rr_mem_wdata, rr_rdata} !== 40'h0) begin
         n_fail++;
         $display("FAIL reset_data: got %h expected 0", {rr_mem_adr, rr_mem_wdata, rr_rdata});
      end
      reset = 1'b1;
   endtask

   task automatic test_single_read();
      apply_reset();
      req  = 3'b001;
      we   = 3'b000;
      addr = {8'h00, 8'h00, 8'h10};
      step();
      n_checks++;
      if ({rr_gnt, rr_mem_en, rr_mem_we, rr_mem_adr} !== {3'b001, 1'b1, 1'b0, 8'h10}) begin
         n_fail++;
         $display("FAIL read_grant: got gnt=%b en=%b we=%b adr=%h expected 001 1 0 10",
                  rr_gnt, rr_mem_en, rr_mem_we, rr_mem_adr);
      end
      req = 3'b000;
      step();
      n_checks++;
      if ({rr_rvalid, rr_rdata, rr_gnt} !== {3'b001, 16'hBEEF, 3'b000}) begin
         n_fail++;
         $display("FAIL read_data: got rvalid=%b rdata=%h gnt=%b expected 001 beef 000",
                  rr_rvalid, rr_rdata, rr_gnt);
      end
   endtask

   task automatic test_round_robin();
      logic [2:0]  exp_g [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      logic [15:0] exp_d [3] = '{16'h1111, 16'h2222, 16'h3333};
      apply_reset();
      req  = 3'b111;
      we   = 3'b000;
      addr = {8'h03, 8'h02, 8'h01};
      for (int k = 0; k < 6; k++) begin
         step();
         n_checks++;
         if (rr_gnt !== exp_g[k] || rr_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rr_order[%0d]: got gnt=%b busy=%b expected %b 1", k, rr_gnt, rr_busy, exp_g[k]);
         end
         if (k > 0) begin
            n_checks++;
            if (rr_rvalid !== exp_g[k-1] || rr_rdata !== exp_d[(k-1)%3]) begin
               n_fail++;
               $display("FAIL rr_rdata[%0d]: got rvalid=%b rdata=%h expected %b %h",
                        k, rr_rvalid, rr_rdata, exp_g[k-1], exp_d[(k-1)%3]);
            end
         end
      end
      req = 3'b000;
   endtask

   task automatic test_fixed_priority();
      logic [2:0] exp_g [4] = '{3'b010, 3'b001, 3'b010, 3'b001};
      apply_reset();
      req  = 3'b011;
      we   = 3'b000;
      addr = {8'h00, 8'h02, 8'h01};
      for (int k = 0; k < 4; k++) begin
         step();
         n_checks++;
         if (fp_gnt !== exp_g[k]) begin
            n_fail++;
            $display("FAIL fp_order[%0d]: got gnt=%b expected %b", k, fp_gnt, exp_g[k]);
         end
      end
      req = 3'b000;
   endtask

   task automatic test_lock();
      apply_reset();
      lock  = 1'b1;
      req   = 3'b100;
      we    = 3'b100;
      addr  = {8'h20, 8'h00, 8'h00};
      wdata = {16'h1234, 16'h0000, 16'h0000};
      step();
      n_checks++;
      if ({rr_gnt, rr_mem_en, rr_mem_we, rr_mem_adr, rr_mem_wdata} !== {3'b100, 1'b1, 1'b1, 8'h20, 16'h1234}) begin
         n_fail++;
         $display("FAIL lock_write: got gnt=%b en=%b we=%b adr=%h wd=%h expected 100 1 1 20 1234",
                  rr_gnt, rr_mem_en, rr_mem_we, rr_mem_adr, rr_mem_wdata);
      end
      req  = 3'b001;
      we   = 3'b000;
      addr = {8'h20, 8'h00, 8'h10};
      for (int k = 0; k < 2; k++) begin
         step();
         n_checks++;
         if ({rr_gnt, rr_rvalid, rr_mem_en, rr_busy, rr_mem_adr} !== {3'b000, 3'b000, 1'b0, 1'b1, 8'h20}) begin
            n_fail++;
            $display("FAIL lock_hold[%0d]: got gnt=%b rvalid=%b en=%b busy=%b adr=%h expected 000 000 0 1 20",
                     k, rr_gnt, rr_rvalid, rr_mem_en, rr_busy, rr_mem_adr);
         end
      end
      n_checks++;
      if ({rr_last_wr_adr, rr_last_wr_data} !== {8'h20, 16'h1234}) begin
         n_fail++;
         $display("FAIL lock_ram: got adr=%h data=%h expected 20 1234", rr_last_wr_adr, rr_last_wr_data);
      end
      lock = 1'b0;
      step();
      n_checks++;
      if (rr_gnt !== 3'b000) begin
         n_fail++;
         $display("FAIL lock_release_edge: got gnt=%b expected 000", rr_gnt);
      end
      step();
      n_checks++;
      if (rr_gnt !== 3'b001) begin
         n_fail++;
         $display("FAIL lock_after: got gnt=%b expected 001", rr_gnt);
      end
      req = 3'b000;
   endtask

   task automatic test_reset_inflight();
      apply_reset();
      req  = 3'b001;
      we   = 3'b000;
      addr = {8'h00, 8'h00, 8'h10};
      step();
      n_checks++;
      if (rr_gnt !== 3'b001) begin
         n_fail++;
         $display("FAIL inflight_grant: got gnt=%b expected 001", rr_gnt);
      end
      reset = 1'b0;
      req   = 3'b000;
      #1;
      n_checks++;
      if ({rr_gnt, rr_rvalid, rr_mem_en, rr_mem_we, rr_mem_adr, rr_mem_wdata, rr_rdata} !== 48'h0) begin
         n_fail++;
         $display("FAIL inflight_async: got gnt=%b rvalid=%b en=%b adr=%h rdata=%h expected all 0",
                  rr_gnt, rr_rvalid, rr_mem_en, rr_mem_adr, rr_rdata);
      end
      step();
      n_checks++;
      if (rr_rvalid !== 3'b000 || rr_rdata !== 16'h0000) begin
         n_fail++;
         $display("FAIL inflight_drop: got rvalid=%b rdata=%h expected 000 0000", rr_rvalid, rr_rdata);
      end
      reset = 1'b1;
      req   = 3'b111;
      addr  = {8'h03, 8'h02, 8'h01};
      step();
      n_checks++;
      if (rr_gnt !== 3'b001) begin
         n_fail++;
         $display("FAIL inflight_first: got gnt=%b expected 001", rr_gnt);
      end
      req = 3'b000;
   endtask

   task automatic test_back_to_back();
      apply_reset();
      req  = 3'b011;
      we   = 3'b000;
      addr = {8'h00, 8'h02, 8'h01};
      step();
      n_checks++;
      if (rr_gnt !== 3'b001 || rr_mem_adr !== 8'h01) begin
         n_fail++;
         $display("FAIL b2b_g0: got gnt=%b adr=%h expected 001 01", rr_gnt, rr_mem_adr);
      end
      req = 3'b010;
      step();
      n_checks++;
      if ({rr_gnt, rr_rvalid, rr_rdata, rr_mem_adr} !== {3'b010, 3'b001, 16'h1111, 8'h02}) begin
         n_fail++;
         $display("FAIL b2b_overlap: got gnt=%b rvalid=%b rdata=%h adr=%h expected 010 001 1111 02",
                  rr_gnt, rr_rvalid, rr_rdata, rr_mem_adr);
      end
      req = 3'b000;
      step();
      n_checks++;
      if ({rr_gnt, rr_rvalid, rr_rdata} !== {3'b000, 3'b010, 16'h2222}) begin
         n_fail++;
         $display("FAIL b2b_second: got gnt=%b rvalid=%b rdata=%h expected 000 010 2222",
                  rr_gnt, rr_rvalid, rr_rdata);
      end
      step();
      n_checks++;
      if ({rr_rvalid, rr_rdata, rr_mem_en, rr_mem_adr, rr_busy} !== {3'b000, 16'h2222, 1'b0, 8'h02, 1'b0}) begin
         n_fail++;
         $display("FAIL b2b_idle_hold: got rvalid=%b rdata=%h en=%b adr=%h busy=%b expected 000 2222 0 02 0",
                  rr_rvalid, rr_rdata, rr_mem_en, rr_mem_adr, rr_busy);
      end
   endtask

   initial begin
      reset = 1'b0;
      req   = 3'b000;
      we    = 3'b000;
      addr  = 24'h0;
      wdata = 48'h0;
      lock  = 1'b0;
      test_reset();
      test_single_read();
      test_round_robin();
      test_fixed_priority();
      test_lock();
      test_reset_inflight();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
